// File: rtl/signed_sat_addsub_pipe_if.sv
// Operand/result handshake bundle for signed_sat_addsub_pipe.
// master = producer of operands / consumer of results, slave = the adder block.
interface signed_sat_addsub_pipe_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         acc_mode;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         ovf;
    logic         sticky_ovf;

    modport master (
        output in_valid, a, b, sub, acc_mode, clear, out_ready,
        input  in_ready, out_valid, sum, ovf, sticky_ovf
    );

    modport slave (
        input  in_valid, a, b, sub, acc_mode, clear, out_ready,
        output in_ready, out_valid, sum, ovf, sticky_ovf
    );
endinterface

// File: rtl/signed_sat_addsub_pipe.sv
// Two-stage signed add/subtract with optional saturation and a chained accumulator.
// The arithmetic is done ahead of S1 so the accumulator can take each result on
// its acceptance edge; S2 is a pure output register.
module signed_sat_addsub_pipe #(
    parameter int unsigned W      = 8,
    parameter bit          SAT_EN = 1'b1
) (
    input logic                        clk,
    input logic                        rst_n,
    signed_sat_addsub_pipe_if.slave    bus
);
    localparam logic [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

    logic         adv, accept, xfer;
    logic [W-1:0] x_op;
    logic [W:0]   raw;
    logic         ovf_c;
    logic [W-1:0] res_c;

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_sum_q, s1_sum_d;
    logic         s1_ovf_q, s1_ovf_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_sum_q, s2_sum_d;
    logic         s2_ovf_q, s2_ovf_d;
    logic [W-1:0] acc_q, acc_d;
    logic         sticky_q, sticky_d;

    // Handshake decode and the W+1-bit add/sub with overflow handling.
    always_comb begin
        adv    = ~s2_valid_q | bus.out_ready;
        accept = bus.in_valid & adv;
        xfer   = s2_valid_q & bus.out_ready;
        // A clear on the same beat makes the accumulator read as zero.
        x_op   = bus.a;
        if (bus.acc_mode) x_op = bus.clear ? '0 : acc_q;
        // Sign-extended W+1-bit arithmetic is exact, including -(-2^(W-1)).
        if (bus.sub) raw = {x_op[W-1], x_op} - {bus.b[W-1], bus.b};
        else         raw = {x_op[W-1], x_op} + {bus.b[W-1], bus.b};
        ovf_c = raw[W] ^ raw[W-1];
        res_c = raw[W-1:0];
        if (SAT_EN && ovf_c) res_c = raw[W] ? MinNeg : MaxPos;
    end

    // Next state for both stages, the accumulator and the sticky flag.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_ovf_d   = s1_ovf_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_ovf_d   = s2_ovf_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        if (adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sum_d = res_c;
                s1_ovf_d = ovf_c;
            end
            s2_valid_d = s1_valid_q;
            s2_sum_d   = s1_sum_q;
            s2_ovf_d   = s1_ovf_q;
        end
        if (accept && bus.acc_mode) acc_d = res_c;
        else if (bus.clear)         acc_d = '0;
        // Set beats clear when both happen on the same edge.
        if (xfer && s2_ovf_q)  sticky_d = 1'b1;
        else if (bus.clear)    sticky_d = 1'b0;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_ovf_q   <= s1_ovf_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_ovf_q   <= s2_ovf_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
        end
    end

    // Outputs come straight from registers; in_ready is the advance term.
    always_comb begin
        bus.in_ready   = adv;
        bus.out_valid  = s2_valid_q;
        bus.sum        = s2_sum_q;
        bus.ovf        = s2_ovf_q;
        bus.sticky_ovf = sticky_q;
    end
endmodule

// File: tb/tb_signed_sat_addsub_pipe.sv
// Directed bench for signed_sat_addsub_pipe at W=4: one saturating and one wrapping instance.
// Inputs change and outputs are sampled on the falling edge.
module tb_signed_sat_addsub_pipe;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    signed_sat_addsub_pipe_if #(.W(4)) bus_s ();
    signed_sat_addsub_pipe_if #(.W(4)) bus_w ();

    signed_sat_addsub_pipe #(.W(4), .SAT_EN(1'b1)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    signed_sat_addsub_pipe #(.W(4), .SAT_EN(1'b0)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required normal completion");
        $fatal(1, "timeout");
    end

    task automatic drive_s(input logic v, input logic [3:0] a, input logic [3:0] b,
                           input logic sub, input logic accm, input logic clr);
        bus_s.in_valid = v;
        bus_s.a        = a;
        bus_s.b        = b;
        bus_s.sub      = sub;
        bus_s.acc_mode = accm;
        bus_s.clear    = clr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_s(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        bus_s.out_ready = 1'b1;
        bus_w.in_valid = 1'b0; bus_w.a = '0; bus_w.b = '0; bus_w.sub = 1'b0;
        bus_w.acc_mode = 1'b0; bus_w.clear = 1'b0; bus_w.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (bus_s.out_valid !== 1'b0) begin fails++;
            $display("FAIL reset_out_valid: got %b required 0", bus_s.out_valid); end
        tests++; if (bus_s.sum !== 4'h0 || bus_s.ovf !== 1'b0) begin fails++;
            $display("FAIL reset_sum_ovf: got %h/%b required 0/0", bus_s.sum, bus_s.ovf); end
        tests++; if (bus_s.sticky_ovf !== 1'b0) begin fails++;
            $display("FAIL reset_sticky: got %b required 0", bus_s.sticky_ovf); end
        rst_n = 1'b1;
        tests++; if (bus_s.in_ready !== 1'b1) begin fails++;
            $display("FAIL reset_in_ready: got %b required 1", bus_s.in_ready); end
    endtask

    // 7 + 1 saturates to 7; sticky sets only once the result transfers.
    task automatic test_sat_pos();
        drive_s(1'b1, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive_s(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (bus_s.out_valid !== 1'b0) begin fails++;
            $display("FAIL sat_pos_latency: out_valid %b after one edge, required 0",
                     bus_s.out_valid); end
        @(posedge clk); @(negedge clk);
        tests++; if (bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'h7 || bus_s.ovf !== 1'b1)
            begin fails++; $display("FAIL sat_pos_result: got v=%b sum=%h ovf=%b required 1/7/1",
                                    bus_s.out_valid, bus_s.sum, bus_s.ovf); end
        tests++; if (bus_s.sticky_ovf !== 1'b0) begin fails++;
            $display("FAIL sat_pos_sticky_early: got %b required 0", bus_s.sticky_ovf); end
        @(posedge clk); @(negedge clk);
        tests++; if (bus_s.sticky_ovf !== 1'b1 || bus_s.out_valid !== 1'b0) begin fails++;
            $display("FAIL sat_pos_sticky: got sticky=%b v=%b required 1/0",
                     bus_s.sticky_ovf, bus_s.out_valid); end
    endtask

    // A lone clear pulse drops the sticky flag.
    task automatic test_clear_sticky();
        bus_s.clear = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_s.clear = 1'b0;
        tests++; if (bus_s.sticky_ovf !== 1'b0) begin fails++;
            $display("FAIL clear_sticky: got %b required 0", bus_s.sticky_ovf); end
    endtask

    // -8 + -1 -> -8, then 0 - (-8) -> 7, on consecutive cycles.
    task automatic test_back_to_back();
        drive_s(1'b1, 4'h8, 4'hF, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive_s(1'b1, 4'h0, 4'h8, 1'b1, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        drive_s(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'h8 || bus_s.ovf !== 1'b1)
            begin fails++; $display("FAIL b2b_first: got v=%b sum=%h ovf=%b required 1/8/1",
                                    bus_s.out_valid, bus_s.sum, bus_s.ovf); end
        @(posedge clk); @(negedge clk);
        tests++; if (bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'h7 || bus_s.ovf !== 1'b1)
            begin fails++; $display("FAIL b2b_second: got v=%b sum=%h ovf=%b required 1/7/1",
                                    bus_s.out_valid, bus_s.sum, bus_s.ovf); end
        @(posedge clk); @(negedge clk);
        tests++; if (bus_s.out_valid !== 1'b0) begin fails++;
            $display("FAIL b2b_drain: out_valid %b required 0", bus_s.out_valid); end
    endtask

    // Wrapping instance: 7 + 1 -> -8 with ovf still flagged.
    task automatic test_wrap();
        bus_w.in_valid = 1'b1; bus_w.a = 4'h7; bus_w.b = 4'h1; bus_w.sub = 1'b0;
        @(posedge clk); @(negedge clk);
        bus_w.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        tests++; if (bus_w.out_valid !== 1'b1 || bus_w.sum !== 4'h8 || bus_w.ovf !== 1'b1)
            begin fails++; $display("FAIL wrap: got v=%b sum=%h ovf=%b required 1/8/1",
                                    bus_w.out_valid, bus_w.sum, bus_w.ovf); end
    endtask

    // clear+acc b=3, then three acc b=3 beats: 3, 6, 7(ovf), 7(ovf).
    task automatic test_accumulate();
        logic [3:0] exp_sum [4];
        logic       exp_ovf [4];
        exp_sum[0] = 4'h3; exp_sum[1] = 4'h6; exp_sum[2] = 4'h7; exp_sum[3] = 4'h7;
        exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0; exp_ovf[2] = 1'b1; exp_ovf[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                tests++;
                if (bus_s.out_valid !== 1'b1 || bus_s.sum !== exp_sum[i-2] ||
                    bus_s.ovf !== exp_ovf[i-2]) begin
                    fails++;
                    $display("FAIL accumulate[%0d]: got v=%b sum=%h ovf=%b required 1/%h/%b",
                             i - 2, bus_s.out_valid, bus_s.sum, bus_s.ovf,
                             exp_sum[i-2], exp_ovf[i-2]);
                end
            end
            if (i < 4) drive_s(1'b1, 4'h0, 4'h3, 1'b0, 1'b1, (i == 0));
            else       drive_s(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); @(negedge clk);
        end
    endtask

    // Stall for 5 cycles with 2 beats in flight and a third waiting.
    task automatic test_stall();
        drive_s(1'b1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);   // 3
        @(posedge clk); @(negedge clk);
        drive_s(1'b1, 4'hD, 4'h1, 1'b1, 1'b0, 1'b0);   // -3 - 1 = -4
        @(posedge clk); @(negedge clk);
        drive_s(1'b1, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0);   // 4, held off by the stall
        bus_s.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            tests++;
            if (bus_s.in_ready !== 1'b0 || bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'h3 ||
                bus_s.ovf !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b sum=%h ovf=%b required 0/1/3/0",
                         i, bus_s.in_ready, bus_s.out_valid, bus_s.sum, bus_s.ovf);
            end
        end
        bus_s.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        drive_s(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tests++; if (bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'hC) begin fails++;
            $display("FAIL stall_second: got v=%b sum=%h required 1/c",
                     bus_s.out_valid, bus_s.sum); end
        @(posedge clk); @(negedge clk);
        tests++; if (bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'h4) begin fails++;
            $display("FAIL stall_third: got v=%b sum=%h required 1/4",
                     bus_s.out_valid, bus_s.sum); end
        @(posedge clk); @(negedge clk);
        tests++; if (bus_s.out_valid !== 1'b0) begin fails++;
            $display("FAIL stall_drain: out_valid %b required 0", bus_s.out_valid); end
    endtask

    // Reset with two accumulate beats in flight (acc=7 beforehand, sticky=1).
    task automatic test_reset_midflight();
        drive_s(1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);   // 7 - 1 = 6
        @(posedge clk); @(negedge clk);
        drive_s(1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);   // 5
        @(posedge clk); @(negedge clk);
        drive_s(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        bus_s.out_ready = 1'b0;
        tests++; if (bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'h6 ||
                     bus_s.sticky_ovf !== 1'b1) begin fails++;
            $display("FAIL pre_reset: got v=%b sum=%h sticky=%b required 1/6/1",
                     bus_s.out_valid, bus_s.sum, bus_s.sticky_ovf); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (bus_s.out_valid !== 1'b0 || bus_s.sticky_ovf !== 1'b0 ||
                     bus_s.sum !== 4'h0) begin fails++;
            $display("FAIL async_reset: got v=%b sticky=%b sum=%h required 0/0/0",
                     bus_s.out_valid, bus_s.sticky_ovf, bus_s.sum); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_s.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            tests++; if (bus_s.out_valid !== 1'b0) begin fails++;
                $display("FAIL reset_discard[%0d]: out_valid %b required 0", i,
                         bus_s.out_valid); end
        end
        // acc must be zero: acc + 0 yields 0 rather than 5.
        drive_s(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        drive_s(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        tests++; if (bus_s.out_valid !== 1'b1 || bus_s.sum !== 4'h0 || bus_s.ovf !== 1'b0)
            begin fails++; $display("FAIL reset_acc: got v=%b sum=%h ovf=%b required 1/0/0",
                                    bus_s.out_valid, bus_s.sum, bus_s.ovf); end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_sat_pos();
        test_clear_sticky();
        test_back_to_back();
        test_wrap();
        test_accumulate();
        test_stall();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
